mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_stage_pkg.sv | 5 +
 rtl/byte_lane_ram.sv | 16 +
 rtl/mem_access_stage.sv | 97 +++++++++
 tb/tb_mem_access_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: access-size and forwarding-select encodings for the memory stage
package mem_stage_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  localparam logic [1:0] FWD_NONE = 2'b00, FWD_LOAD = 2'b01, FWD_ALU = 2'b10;
endpackage

// File: rtl/byte_lane_ram.sv
// byte_lane_ram: 32-bit word memory with per-byte write enables and asynchronous read
module byte_lane_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [3:0]            i_be,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);
  logic [31:0] r_mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage with multi-cycle access, store forwarding and MEM/WB register
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LAT        = 1,
  parameter int REG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [1:0]       ex_size,
  input  logic             ex_unsigned,
  input  logic [31:0]      ex_addr,
  input  logic [31:0]      ex_store_data,
  input  logic [REG_W-1:0] ex_store_src,
  input  logic [REG_W-1:0] ex_write_reg,
  output logic             stall,
  output logic [1:0]       fwd_sel,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic             wb_misalign,
  output logic [31:0]      wb_alu_result,
  output logic [31:0]      wb_read_data,
  output logic [REG_W-1:0] wb_write_reg
);
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_ret_valid, r_ret_load;
  logic [REG_W-1:0] r_ret_reg;
  logic [31:0]      r_ret_data;
  logic             w_acc, w_mis, w_mem_op, w_fwd, w_we;
  logic [3:0]       w_be;
  logic [15:0]      w_lane;
  logic [31:0]      w_sdata, w_wdata, w_rdata, w_load;
  assign w_acc    = ex_mem_read || ex_mem_write;
  assign w_mis    = w_acc && ((ex_size == SZ_HALF && ex_addr[0]) ||
                              (ex_size == SZ_WORD && ex_addr[1:0] != 2'b00));
  assign w_mem_op = ex_valid && w_acc && !w_mis;
  assign stall    = w_mem_op && r_cnt != 4'(LAT - 1);
  assign w_cnt_nxt = stall ? r_cnt + 4'd1 : 4'd0;
  // The retiring writer's value wins over the stale register-file read from EX
  assign w_fwd   = ex_mem_write && r_ret_valid && r_ret_reg == ex_store_src && ex_store_src != '0;
  assign fwd_sel = !w_fwd ? FWD_NONE : r_ret_load ? FWD_LOAD : FWD_ALU;
  assign w_sdata = w_fwd ? r_ret_data : ex_store_data;
  assign w_we    = w_mem_op && ex_mem_write && !stall && !reset;
  assign w_wdata = ex_size == SZ_BYTE ? {4{w_sdata[7:0]}} :
                   ex_size == SZ_HALF ? {2{w_sdata[15:0]}} : w_sdata;
  assign w_be    = !w_we ? 4'b0000 :
                   ex_size == SZ_BYTE ? 4'b0001 << ex_addr[1:0] :
                   ex_size == SZ_HALF ? (ex_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_lane  = 16'(w_rdata >> {ex_addr[1:0], 3'b000});
  assign w_load  = w_mis ? 32'h0 :
                   ex_size == SZ_BYTE ? {{24{!ex_unsigned && w_lane[7]}}, w_lane[7:0]} :
                   ex_size == SZ_HALF ? {{16{!ex_unsigned && w_lane[15]}}, w_lane} : w_rdata;
  byte_lane_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk    (clk),
    .i_be   (w_be),
    .i_addr (ex_addr[DEPTH_LOG2+1:2]),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_ret_valid   <= 1'b0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_misalign   <= 1'b0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_write_reg  <= '0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      wb_valid     <= ex_valid && !stall;
      wb_reg_write <= ex_reg_write && !stall;
      if (!stall) begin
        wb_mem_to_reg <= ex_mem_to_reg;
        wb_misalign   <= w_mis;
        wb_alu_result <= ex_addr;
        wb_read_data  <= w_load;
        wb_write_reg  <= ex_write_reg;
      end
      if (!stall && ex_valid && ex_reg_write) begin
        r_ret_valid <= 1'b1;
        r_ret_reg   <= ex_write_reg;
        r_ret_load  <= ex_mem_to_reg;
        r_ret_data  <= ex_mem_to_reg ? w_load : ex_addr;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench over LAT=1/3/4 instances of the memory stage
module tb_mem_access_stage;
  import mem_stage_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic ex_valid = 0, ex_reg_write = 0, ex_mem_to_reg = 0, ex_mem_read = 0, ex_mem_write = 0, ex_unsigned = 0;
  logic [1:0] ex_size = '0;
  logic [31:0] ex_addr = '0, ex_store_data = '0;
  logic [4:0] ex_store_src = '0, ex_write_reg = '0;
  int sel = 0, lat_cur = 1, errors = 0, checks = 0;
  logic stall_a [3], v_a [3], rw_a [3], m2r_a [3], mis_a [3];
  logic [1:0] fwd_a [3];
  logic [31:0] alu_a [3], rd_a [3];
  logic [4:0] wr_a [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_stage #(.DEPTH_LOG2(10), .LAT(g == 0 ? 1 : g + 2), .REG_W(5)) u_dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid && sel == g), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_size(ex_size),
      .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
      .ex_store_src(ex_store_src), .ex_write_reg(ex_write_reg),
      .stall(stall_a[g]), .fwd_sel(fwd_a[g]), .wb_valid(v_a[g]), .wb_reg_write(rw_a[g]),
      .wb_mem_to_reg(m2r_a[g]), .wb_misalign(mis_a[g]), .wb_alu_result(alu_a[g]),
      .wb_read_data(rd_a[g]), .wb_write_reg(wr_a[g])
    );
  end
  typedef struct {
    logic [31:0] alu, rd;
    bit chk_rd, mis, rw, m2r;
    logic [4:0] wr;
  } exp_t;
  exp_t q[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!reset && v_a[sel]) begin
      if (q.size() == 0) check("unexpected_wb_valid", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("wb_alu_result", alu_a[sel], e.alu);
        check("wb_misalign", 32'(mis_a[sel]), 32'(e.mis));
        check("wb_reg_write", 32'(rw_a[sel]), 32'(e.rw));
        check("wb_mem_to_reg", 32'(m2r_a[sel]), 32'(e.m2r));
        check("wb_write_reg", 32'(wr_a[sel]), 32'(e.wr));
        if (e.chk_rd) check("wb_read_data", rd_a[sel], e.rd);
      end
    end
  end
  task automatic issue(input bit rd, input bit wr, input bit rw, input bit m2r, input logic [1:0] sz,
                       input bit us, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] src, input logic [4:0] dst, input bit chk_rd,
                       input logic [31:0] erd, input int efwd);
    bit mis = (rd || wr) && ((sz == SZ_HALF && addr[0]) || (sz == SZ_WORD && addr[1:0] != 2'b00));
    int n = 0;
    ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw; ex_mem_to_reg = m2r;
    ex_size = sz; ex_unsigned = us; ex_addr = addr; ex_store_data = sd;
    ex_store_src = src; ex_write_reg = dst;
    q.push_back('{alu: addr, rd: mis ? 32'h0 : erd, chk_rd: chk_rd || mis, mis: mis, rw: rw, m2r: m2r, wr: dst});
    forever begin
      #1;
      if (efwd >= 0) check("fwd_sel", 32'(fwd_a[sel]), efwd);
      if (!stall_a[sel] || n > 10) break;
      n++;
      @(negedge clk);
      check("bubble_wb_valid", 32'(v_a[sel]), 32'd0);
    end
    check("stall_cycles", n, ((rd || wr) && !mis) ? lat_cur - 1 : 0);
    @(negedge clk);
  endtask
  task automatic ld(input logic [4:0] dst, input logic [1:0] sz, input bit us, input logic [31:0] addr, input logic [31:0] erd);
    issue(1, 0, 1, 1, sz, us, addr, 32'h0, 5'd0, dst, 1, erd, -1);
  endtask
  task automatic st(input logic [4:0] src, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] sd, input int efwd);
    issue(0, 1, 0, 0, sz, 0, addr, sd, src, 5'd0, 0, 32'h0, efwd);
  endtask
  task automatic alu(input logic [4:0] dst, input logic [31:0] val);
    issue(0, 0, 1, 0, SZ_WORD, 0, val, 32'h0, 5'd0, dst, 0, 32'h0, -1);
  endtask
  task automatic idle(input int n);
    ex_valid = 0;
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    ex_valid = 0; reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    do_reset();
    check("rst_wb_valid", 32'(v_a[0]), 32'd0);
    check("rst_stall", 32'(stall_a[0]), 32'd0);
    check("rst_wb_read_data", rd_a[0], 32'd0);
    check("rst_wb_alu_result", alu_a[0], 32'd0);
    check("rst_wb_misalign", 32'(mis_a[0]), 32'd0);
    check("rst_wb_reg_write", 32'(rw_a[0]), 32'd0);
    st(0, SZ_WORD, 32'h10, 32'h11223344, FWD_NONE);
    ld(1, SZ_WORD, 0, 32'h10, 32'h11223344);
    st(0, SZ_BYTE, 32'h13, 32'h00000080, FWD_NONE);
    ld(2, SZ_BYTE, 0, 32'h13, 32'hFFFFFF80);
    ld(2, SZ_BYTE, 1, 32'h13, 32'h00000080);
    ld(2, SZ_WORD, 0, 32'h10, 32'h80223344);
    st(0, SZ_HALF, 32'h12, 32'h0000BEEF, FWD_NONE);
    ld(2, SZ_HALF, 0, 32'h12, 32'hFFFFBEEF);
    ld(2, SZ_HALF, 1, 32'h12, 32'h0000BEEF);
    ld(2, SZ_BYTE, 0, 32'h10, 32'h00000044);
    ld(2, SZ_WORD, 0, 32'h10, 32'hBEEF3344);
    st(0, SZ_WORD, 32'h30, 32'hCAFE0000, FWD_NONE);
    ld(3, SZ_WORD, 0, 32'h30, 32'hCAFE0000);
    st(3, SZ_WORD, 32'h20, 32'h00000000, FWD_LOAD);
    ld(4, SZ_WORD, 0, 32'h20, 32'hCAFE0000);
    alu(5, 32'h12345678);
    st(5, SZ_WORD, 32'h24, 32'h00000000, FWD_ALU);
    ld(6, SZ_WORD, 0, 32'h24, 32'h12345678);
    ld(7, SZ_HALF, 0, 32'h21, 32'h0);
    st(0, SZ_WORD, 32'h22, 32'hDEADBEEF, FWD_NONE);
    ld(8, SZ_WORD, 0, 32'h20, 32'hCAFE0000);
    st(0, SZ_WORD, 32'h1030, 32'h5A5A5A5A, FWD_NONE);
    ld(8, SZ_WORD, 0, 32'h30, 32'h5A5A5A5A);
    idle(2);
    sel = 1; lat_cur = 3;
    do_reset();
    st(0, SZ_WORD, 32'h40, 32'hA5A5A5A5, FWD_NONE);
    ld(1, SZ_WORD, 0, 32'h40, 32'hA5A5A5A5);
    st(0, SZ_WORD, 32'h44, 32'hCAFE0000, FWD_NONE);
    ld(3, SZ_WORD, 0, 32'h44, 32'hCAFE0000);
    st(3, SZ_WORD, 32'h48, 32'h00000000, FWD_LOAD);
    ld(4, SZ_WORD, 0, 32'h48, 32'hCAFE0000);
    ld(5, SZ_HALF, 0, 32'h21, 32'h0);
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_reg_write = 1; ex_mem_to_reg = 1;
    ex_size = SZ_WORD; ex_addr = 32'h40; ex_write_reg = 5'd9;
    @(negedge clk);
    alu(6, 32'h00000077);
    ld(1, SZ_WORD, 0, 32'h40, 32'hA5A5A5A5);
    idle(2);
    sel = 2; lat_cur = 4;
    do_reset();
    st(0, SZ_WORD, 32'h50, 32'h600DF00D, FWD_NONE);
    ex_valid = 1; ex_mem_read = 0; ex_mem_write = 1; ex_reg_write = 0; ex_mem_to_reg = 0;
    ex_size = SZ_WORD; ex_addr = 32'h50; ex_store_data = 32'hBAD0BAD0; ex_store_src = 5'd0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0; ex_valid = 0;
    #1;
    check("abort_stall", 32'(stall_a[2]), 32'd0);
    check("abort_wb_valid", 32'(v_a[2]), 32'd0);
    @(negedge clk);
    ld(1, SZ_WORD, 0, 32'h50, 32'h600DF00D);
    idle(2);
    check("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
